rotate_left_seq: RTL and testbench
==================================

ROTATE_LEFT_SEQ -- requirements
Module: rotate_left_seq

Interface
REQ-001 The block SHALL provide parameter N, default 8, operand width in bits.
REQ-002 The block SHALL provide parameter W, default 3, rotate-amount width (2**W == N).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request pulse; sampled only while ready=1.
REQ-006 The block SHALL have port a  input  N  operand, captured on accepted start.
REQ-007 The block SHALL have port amt  input  W  left-rotate amount, captured on accepted start.
REQ-008 The block SHALL have port ready  output  1  high only in IDLE; start accepted when high.
REQ-009 The block SHALL have port done_tick  output  1  one-cycle pulse, result valid.
REQ-010 The block SHALL have port r_out  output  N  rotate-left result, registered.

Function
REQ-011 The block SHALL compute r_out = (a << amt) | (a >> (N - amt)) modulo N bits, one bit position per clock.
REQ-012 The FSM SHALL have exactly three states: IDLE, ROT, DONE.
REQ-013 In IDLE with start=1, it SHALL load data register <= a and count register <= amt, then go to ROT if amt != 0, else go to DONE.
REQ-014 In IDLE with start=0, the state, data register and count register SHALL all hold.
REQ-015 In ROT, each cycle it SHALL set data <= {data[N-2:0], data[N-1]} and count <= count - 1.
REQ-016 In ROT, it SHALL go to DONE on the cycle where count == 1; otherwise it SHALL stay in ROT.
REQ-017 In DONE, it SHALL assert done_tick=1 for exactly that one cycle, then go to IDLE unconditionally.
REQ-018 r_out SHALL equal the data register at all times.
REQ-019 r_out SHALL hold the final result from DONE through IDLE until the next accepted start reloads it.
REQ-020 Latency SHALL be fixed: start accepted at edge 0 gives done_tick high in cycle amt+1 (amt=0 gives cycle 1; amt=N-1 gives cycle N).
REQ-021 start SHALL be ignored in ROT and DONE; in-flight operands SHALL NOT be disturbed and no request SHALL be queued.
REQ-022 ready SHALL be 0 in ROT and DONE.
REQ-023 A start asserted in the cycle after done_tick (IDLE) SHALL be accepted, giving back-to-back throughput of amt+2 cycles per operation.
REQ-024 Changes on a or amt after acceptance SHALL NOT affect the result in progress.
REQ-025 The count register SHALL be W bits wide and SHALL never wrap, since ROT exits at count==1.

Reset
REQ-026 Asserting reset SHALL immediately, independent of clk, force state=IDLE, data=0, count=0.
REQ-027 While reset is asserted, outputs SHALL be ready=1, done_tick=0, r_out=0.
REQ-028 Reset asserted mid-ROT or in DONE SHALL abort the operation without any done_tick pulse.
REQ-029 On release of reset, the first accepted start SHALL behave per REQ-013.

Verification
REQ-030 a=8'b1001_0110, amt=3, start pulse -> ready falls next cycle; done_tick in cycle 4; r_out=8'b1011_0100; ready=1 in cycle 5.
REQ-031 a=8'hA5, amt=0 -> done_tick in cycle 1, r_out=8'hA5, no ROT cycles.
REQ-032 a=8'h01, amt=7 -> done_tick in cycle 8, r_out=8'h80; exhaustive sweep of all a x all amt matches the reference model (a<<amt)|(a>>(8-amt)).
REQ-033 a=8'h81, amt=2 accepted, then start=1 with a=8'hFF, amt=5 held during ROT -> single done_tick, r_out=8'h06, second request not executed.
REQ-034 a=8'hF0, amt=6 accepted, reset pulsed in cycle 3 -> r_out=0, ready=1, no done_tick; a subsequent start with a=8'h0F, amt=1 gives r_out=8'h1E in cycle 2.
REQ-035 Back-to-back: start held high continuously with amt=1 -> done_tick every 3 cycles, results correct each time.

Source files
------------

// File: rtl/rotate_left_seq.sv
// ---------------------------------------------------------------------------
// rotate_left_seq
//
// Sequential left rotator. An operand is captured on an accepted start and
// rotated left by one bit position per clock until the requested amount has
// been applied. A one-cycle done_tick then flags the result, and the block
// returns to idle.
//
// Parameters
//   N          operand width in bits
//   W          rotate-amount width, with 2**W == N
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   start      request pulse, only looked at while ready is high
//   a          operand, captured on an accepted start
//   amt        left-rotate amount, captured on an accepted start
//   ready      high only while idle, which is when a start is accepted
//   done_tick  one-cycle pulse, r_out holds the finished result
//   r_out      rotate-left result, taken straight from the data register
// ---------------------------------------------------------------------------
module rotate_left_seq #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [W-1:0] amt,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] r_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] data;
  logic [W-1:0] count;

  // Control and datapath share one register block. ready and done_tick are
  // registered alongside the state so they change on the same edge as the
  // state they describe. The counter leaves ROT when it reads 1, so it never
  // decrements past zero. An amount of zero skips ROT entirely and goes
  // straight to DONE. start is ignored outside IDLE, so nothing is queued
  // and the operands already captured cannot be disturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data      <= '0;
      count     <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data  <= a;
            count <= amt;
            ready <= 1'b0;
            if (amt != '0) begin
              state     <= ROT;
              done_tick <= 1'b0;
            end else begin
              state     <= DONE;
              done_tick <= 1'b1;
            end
          end
        end
        ROT: begin
          data  <= {data[N-2:0], data[N-1]};
          count <= count - W'(1);
          if (count == W'(1)) begin
            state     <= DONE;
            done_tick <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ready     <= 1'b1;
          done_tick <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          done_tick <= 1'b0;
        end
      endcase
    end
  end

  // The result is the data register itself. It therefore holds the finished
  // value through DONE and IDLE until the next accepted start reloads it.
  assign r_out = data;

endmodule

// File: tb/tb_rotate_left_seq.sv
// ---------------------------------------------------------------------------
// tb_rotate_left_seq
//
// Self-checking bench for rotate_left_seq with N=8, W=3. Each accepted
// request pushes its expected result onto a queue. When done_tick is seen,
// the oldest entry is popped and compared against r_out. Latency is counted
// in cycles after the accepting edge.
//
// Ports
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_rotate_left_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic       ready;
  logic       done_tick;
  logic [7:0] r_out;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expq[$];

  rotate_left_seq #(
    .N(8),
    .W(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .amt      (amt),
    .ready    (ready),
    .done_tick(done_tick),
    .r_out    (r_out)
  );

  // Free-running clock with a 10-unit period. The first rising edge is at
  // time 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rotate, written from the arithmetic definition:
  // (v << s) | (v >> (8 - s)), truncated to 8 bits.
  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    int wide;
    wide = (int'(v) << s) | (int'(v) >> (8 - s));
    return wide[7:0];
  endfunction

  // Wait for ready at a falling edge and present one request. The expected
  // result is pushed to the queue. The task returns just after the
  // accepting rising edge, with start already dropped.
  task automatic applyStimulus(input logic [7:0] av, input logic [2:0] sv);
    @(negedge clk);
    for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge clk);
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_wait: ready=%b required 1", ready);
    end
    a     = av;
    amt   = sv;
    start = 1'b1;
    expq.push_back(rotl(av, sv));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges until done_tick is seen. The count is 1 for the
  // cycle right after the accepting edge. A result of 0 means done_tick was
  // not seen within the budget.
  task automatic waitDone(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [7:0] popExpected();
    if (expq.size() == 0) return 8'hxx;
    return expq.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    amt   = '0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || r_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async: ready=%b done=%b r_out=%h required 1 0 00",
               ready, done_tick, r_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || r_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_held: ready=%b done=%b r_out=%h required 1 0 00",
               ready, done_tick, r_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] exp_r;
    applyStimulus(8'b1001_0110, 3'd3);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_ready_low: ready=%b required 0", ready);
    end
    waitDone(lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("[TB] FAIL basic_latency: cycle=%0d required 4", lat);
    end
    exp_r = popExpected();
    checks++;
    if (r_out !== exp_r || r_out !== 8'b1011_0100) begin
      errors++;
      $display("[TB] FAIL basic_result: r_out=%h required %h", r_out, exp_r);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || r_out !== 8'hB4) begin
      errors++;
      $display("[TB] FAIL basic_after: ready=%b done=%b r_out=%h required 1 0 b4",
               ready, done_tick, r_out);
    end
  endtask

  task automatic test_zero_amt();
    int lat;
    logic [7:0] exp_r;
    applyStimulus(8'hA5, 3'd0);
    waitDone(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("[TB] FAIL zero_latency: cycle=%0d required 1", lat);
    end
    exp_r = popExpected();
    checks++;
    if (r_out !== exp_r) begin
      errors++;
      $display("[TB] FAIL zero_result: r_out=%h required %h", r_out, exp_r);
    end
  endtask

  // While idle with start low, operand changes must not disturb the
  // previous result (A5 from the zero-amount test).
  task automatic test_idle_hold();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a   = 8'($urandom);
      amt = 3'($urandom);
      checks++;
      if (r_out !== 8'hA5 || ready !== 1'b1 || done_tick !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_hold: r_out=%h ready=%b done=%b required a5 1 0",
                 r_out, ready, done_tick);
      end
    end
  endtask

  task automatic test_max_amt();
    int lat;
    logic [7:0] exp_r;
    applyStimulus(8'h01, 3'd7);
    waitDone(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("[TB] FAIL max_latency: cycle=%0d required 8", lat);
    end
    exp_r = popExpected();
    checks++;
    if (r_out !== exp_r || r_out !== 8'h80) begin
      errors++;
      $display("[TB] FAIL max_result: r_out=%h required %h", r_out, exp_r);
    end
  endtask

  // Every operand with every amount. The inputs are scrambled right after
  // acceptance, so any sensitivity to late input changes would show.
  task automatic test_sweep();
    int lat;
    logic [7:0] exp_r;
    for (int av = 0; av < 256; av++) begin
      for (int sv = 0; sv < 8; sv++) begin
        applyStimulus(8'(av), 3'(sv));
        a   = 8'($urandom);
        amt = 3'($urandom);
        waitDone(lat);
        checks++;
        if (lat !== sv + 1) begin
          errors++;
          $display("[TB] FAIL sweep_latency a=%h amt=%0d: cycle=%0d required %0d",
                   av[7:0], sv, lat, sv + 1);
        end
        exp_r = popExpected();
        checks++;
        if (r_out !== exp_r) begin
          errors++;
          $display("[TB] FAIL sweep_result a=%h amt=%0d: r_out=%h required %h",
                   av[7:0], sv, r_out, exp_r);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit extra;
    logic [7:0] exp_r;
    applyStimulus(8'h81, 3'd2);
    a     = 8'hFF;
    amt   = 3'd5;
    start = 1'b1;
    waitDone(lat);
    start = 1'b0;
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("[TB] FAIL busy_latency: cycle=%0d required 3", lat);
    end
    exp_r = popExpected();
    checks++;
    if (r_out !== exp_r || r_out !== 8'h06) begin
      errors++;
      $display("[TB] FAIL busy_result: r_out=%h required %h", r_out, exp_r);
    end
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_tick === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra || r_out !== 8'h06 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_no_queue: extra_done=%b r_out=%h ready=%b required 0 06 1",
               extra, r_out, ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    logic [7:0] exp_r;
    applyStimulus(8'hF0, 3'd6);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (r_out !== 8'h00 || ready !== 1'b1 || done_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset: r_out=%h ready=%b done=%b required 00 1 0",
               r_out, ready, done_tick);
    end
    expq.delete();
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || r_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_no_done: done_seen=%b r_out=%h required 0 00", seen, r_out);
    end
    applyStimulus(8'h0F, 3'd1);
    waitDone(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("[TB] FAIL abort_restart_latency: cycle=%0d required 2", lat);
    end
    exp_r = popExpected();
    checks++;
    if (r_out !== exp_r || r_out !== 8'h1E) begin
      errors++;
      $display("[TB] FAIL abort_restart_result: r_out=%h required %h", r_out, exp_r);
    end
  endtask

  // start stays high throughout. The next operand is presented when
  // done_tick is seen and is accepted two edges later, in IDLE.
  task automatic test_back_to_back();
    logic [7:0] vals[4];
    logic [7:0] exp_r;
    int cnt;
    vals = '{8'h3C, 8'h81, 8'hFF, 8'h5A};
    @(negedge clk);
    a     = vals[0];
    amt   = 3'd1;
    start = 1'b1;
    expq.push_back(rotl(vals[0], 1));
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (done_tick === 1'b1) begin
          cnt = i;
          break;
        end
      end
      checks++;
      if (cnt !== ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("[TB] FAIL b2b_spacing op=%0d: cycles=%0d required %0d",
                 k, cnt, (k == 0) ? 2 : 3);
      end
      exp_r = popExpected();
      checks++;
      if (r_out !== exp_r) begin
        errors++;
        $display("[TB] FAIL b2b_result op=%0d: r_out=%h required %h", k, r_out, exp_r);
      end
      if (k < 3) begin
        a = vals[k+1];
        expq.push_back(rotl(vals[k+1], 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  // Run the scenarios in order, then confirm that no expectation was left
  // unconsumed.
  initial begin
    test_reset();
    test_basic();
    test_zero_amt();
    test_idle_hold();
    test_max_amt();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_empty: pending=%0d required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
